// File: rtl/menu_control.sv
// Menu sequencer for the maze game: debounces the three push-buttons, tracks the selected option,
// blinks the cursor, and moves through MENU -> PLAY -> END -> MENU. Every output comes from a flop.
module menu_control #(
  parameter int DEB_COUNT    = 500000,
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_enter,
  input  logic frame_tick,
  input  logic game_over,
  output logic menu,
  output logic menu_active,
  output logic cursor_blink,
  output logic game_start
);

  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_COUNT);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_FRAMES);

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_ENTER = 2;

  typedef enum logic [1:0] {
    S_MENU = 2'd0,
    S_PLAY = 2'd1,
    S_END  = 2'd2
  } state_t;

  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    level_q;
  logic [2:0]    level_prev_q;
  logic [2:0]    press_q;
  logic [CW-1:0] deb_cnt_q [3];

  state_t        state_q;
  logic          menu_q;
  logic          menu_active_q;
  logic          cursor_blink_q;
  logic          game_start_q;
  logic [BW-1:0] blink_cnt_q;
  logic [HW-1:0] hold_q;

  logic          up_p;
  logic          down_p;
  logic          enter_p;

  assign btn_raw = {btn_enter, btn_down, btn_up};
  assign up_p    = press_q[B_UP];
  assign down_p  = press_q[B_DOWN];
  assign enter_p = press_q[B_ENTER];

  // The level only moves once the counter has run to DEB_COUNT with the synced input
  // still disagreeing; any cycle of agreement restarts the count from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          level_q[i]   <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_MENU;
      menu_q         <= 1'b0;
      menu_active_q  <= 1'b1;
      cursor_blink_q <= 1'b1;
      game_start_q   <= 1'b0;
      blink_cnt_q    <= '0;
      hold_q         <= '0;
    end else begin
      game_start_q <= 1'b0;
      case (state_q)
        S_MENU: begin
          if (enter_p) begin
            // Enter wins over a same-cycle up/down, so the selection is frozen as it was.
            state_q        <= S_PLAY;
            game_start_q   <= 1'b1;
            menu_active_q  <= 1'b0;
            cursor_blink_q <= 1'b1;
            blink_cnt_q    <= '0;
          end else begin
            if (up_p ^ down_p) begin
              menu_q <= ~menu_q;
            end
            if (frame_tick) begin
              if (blink_cnt_q == BLINK_LAST) begin
                cursor_blink_q <= ~cursor_blink_q;
                blink_cnt_q    <= '0;
              end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
              end
            end
          end
        end
        S_PLAY: begin
          if (game_over) begin
            state_q <= S_END;
            hold_q  <= HOLD_INIT;
          end
        end
        S_END: begin
          if (enter_p || (frame_tick && hold_q <= HW'(1))) begin
            state_q       <= S_MENU;
            menu_active_q <= 1'b1;
            hold_q        <= '0;
          end else if (frame_tick) begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: begin
          state_q       <= S_MENU;
          menu_active_q <= 1'b1;
        end
      endcase
    end
  end

  assign menu         = menu_q;
  assign menu_active  = menu_active_q;
  assign cursor_blink = cursor_blink_q;
  assign game_start   = game_start_q;

endmodule

// File: tb/tb_menu_control.sv
// Directed bench for menu_control with short debounce/blink/hold parameters.
module tb_menu_control;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_down, btn_enter, frame_tick, game_over;
  logic menu, menu_active, cursor_blink, game_start;

  int n_cmp  = 0;
  int n_fail = 0;

  menu_control #(
    .DEB_COUNT   (4),
    .BLINK_FRAMES(2),
    .HOLD_FRAMES (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_enter   (btn_enter),
    .frame_tick  (frame_tick),
    .game_over   (game_over),
    .menu        (menu),
    .menu_active (menu_active),
    .cursor_blink(cursor_blink),
    .game_start  (game_start)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_up();
    btn_up = 1'b1; step(10); btn_up = 1'b0; step(10);
  endtask

  task automatic press_down();
    btn_down = 1'b1; step(10); btn_down = 1'b0; step(10);
  endtask

  task automatic press_enter();
    btn_enter = 1'b1; step(10); btn_enter = 1'b0; step(10);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1; step(1); frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    step(3);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_cmp++; if (menu !== 1'b0) begin n_fail++; $display("FAIL reset_menu c%0d: got %b want 0", i, menu); end
      n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL reset_active c%0d: got %b want 1", i, menu_active); end
      n_cmp++; if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL reset_blink c%0d: got %b want 1", i, cursor_blink); end
      n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL reset_start c%0d: got %b want 0", i, game_start); end
    end
  endtask

  task automatic test_debounce();
    // btn_down first sampled at edge k; menu must flip at edge k+8, not before.
    btn_down = 1'b1;
    step(8);
    n_cmp++; if (menu !== 1'b0) begin n_fail++; $display("FAIL down_early: got %b want 0", menu); end
    step(1);
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL down_at_k8: got %b want 1", menu); end
    step(20);
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL down_held: got %b want 1", menu); end
    btn_down = 1'b0; step(12);
    btn_up = 1'b1; step(3); btn_up = 1'b0; step(15);
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL up_glitch: got %b want 1", menu); end
    press_up();
    n_cmp++; if (menu !== 1'b0) begin n_fail++; $display("FAIL up_press: got %b want 0", menu); end
  endtask

  task automatic test_blink();
    pulse_tick();
    n_cmp++; if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL blink_t1: got %b want 1", cursor_blink); end
    step(2); pulse_tick();
    n_cmp++; if (cursor_blink !== 1'b0) begin n_fail++; $display("FAIL blink_t2: got %b want 0", cursor_blink); end
    step(2); pulse_tick();
    n_cmp++; if (cursor_blink !== 1'b0) begin n_fail++; $display("FAIL blink_t3: got %b want 0", cursor_blink); end
    step(2); pulse_tick();
    n_cmp++; if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL blink_t4: got %b want 1", cursor_blink); end
  endtask

  task automatic test_start();
    press_down();
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL start_sel: got %b want 1", menu); end
    btn_enter = 1'b1;
    step(8);
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL start_early: got %b want 0", game_start); end
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL start_active_pre: got %b want 1", menu_active); end
    step(1);
    n_cmp++; if (game_start !== 1'b1) begin n_fail++; $display("FAIL start_pulse: got %b want 1", game_start); end
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL start_active: got %b want 0", menu_active); end
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL start_menu: got %b want 1", menu); end
    step(1);
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL start_width: got %b want 0", game_start); end
    btn_enter = 1'b0; step(10);
    press_down();
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL play_down: got %b want 1", menu); end
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL play_active: got %b want 0", menu_active); end
  endtask

  task automatic test_end_hold();
    game_over = 1'b1; step(1); game_over = 1'b0;
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL end_entry: got %b want 0", menu_active); end
    step(2); pulse_tick();
    step(2); pulse_tick();
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL end_tick2: got %b want 0", menu_active); end
    step(2); pulse_tick();
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL end_tick3: got %b want 1", menu_active); end
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL end_menu_kept: got %b want 1", menu); end
    press_enter();
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL replay_active: got %b want 0", menu_active); end
    game_over = 1'b1; step(1); game_over = 1'b0;
    step(2); pulse_tick();
    btn_enter = 1'b1;
    step(8);
    n_cmp++; if (menu_active !== 1'b0) begin n_fail++; $display("FAIL skip_early: got %b want 0", menu_active); end
    step(1);
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL skip_active: got %b want 1", menu_active); end
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL skip_nostart: got %b want 0", game_start); end
    step(1);
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL skip_nostart2: got %b want 0", game_start); end
    btn_enter = 1'b0; step(10);
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL skip_stay: got %b want 1", menu_active); end
  endtask

  task automatic test_reset_mid_game();
    btn_enter = 1'b1;
    step(9);
    n_cmp++; if (game_start !== 1'b1) begin n_fail++; $display("FAIL rst_pre_start: got %b want 1", game_start); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", game_start); end
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL rst_active: got %b want 1", menu_active); end
    n_cmp++; if (menu !== 1'b0) begin n_fail++; $display("FAIL rst_menu: got %b want 0", menu); end
    n_cmp++; if (cursor_blink !== 1'b1) begin n_fail++; $display("FAIL rst_blink: got %b want 1", cursor_blink); end
    btn_enter = 1'b0;
    @(negedge clk) reset = 1'b0;
    step(20);
    n_cmp++; if (menu_active !== 1'b1) begin n_fail++; $display("FAIL rst_after_active: got %b want 1", menu_active); end
    n_cmp++; if (game_start !== 1'b0) begin n_fail++; $display("FAIL rst_after_start: got %b want 0", game_start); end
  endtask

  task automatic test_up_down_same();
    btn_up = 1'b1; btn_down = 1'b1;
    step(10);
    btn_up = 1'b0; btn_down = 1'b0;
    step(10);
    n_cmp++; if (menu !== 1'b0) begin n_fail++; $display("FAIL updown_same: got %b want 0", menu); end
    press_up();
    n_cmp++; if (menu !== 1'b1) begin n_fail++; $display("FAIL updown_then_up: got %b want 1", menu); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_blink();
    test_start();
    test_end_hold();
    test_reset_mid_game();
    test_up_down_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
